// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and the execution unit.
//   opcode_t      : 4-bit opcode; encodings 9..15 are invalid
//   operand_t     : 32-bit signed operand
//   address_t     : 5-bit instruction register slot address
//   rezultat      : 64-bit signed result
//   instruction_t : {opc, op_a, op_b}
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7,
    POW   = 4'd8
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic        [4:0]  address_t;
  typedef logic signed [63:0] rezultat;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

endpackage

// File: rtl/instr_exec_unit.sv
// Instruction execution unit. Fetches one instruction from the instruction
// register, executes it, and presents the result with a valid/ready handshake
// plus a one-cycle write-back strobe.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   start_valid/start_ready      request handshake, start_addr = slot to run
//   read_pointer                 instruction register read address
//   instruction_word             instruction register read data (comb.)
//   result_valid/result_ready    result handshake
//   result, result_opc, result_addr   result payload
//   wr_en, wr_addr, wr_rez       write-back strobe into the slot executed
//   bad_opc                      sticky flag: last executed opcode invalid
//
// state | meaning
// IDLE  | waiting for start_valid, start_ready = 1
// FETCH | read_pointer set, capture instruction_word
// EXEC  | compute; one cycle, or POW_STEPS cycles for POW
// DONE  | result_valid held until result_ready
module instr_exec_unit
  import instr_register_pkg::*;
#(
  parameter int POW_STEPS = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start_valid,
  input  address_t     start_addr,
  output logic         start_ready,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic         result_valid,
  input  logic         result_ready,
  output rezultat      result,
  output opcode_t      result_opc,
  output address_t     result_addr,
  output logic         wr_en,
  output address_t     wr_addr,
  output rezultat      wr_rez,
  output logic         bad_opc
);

  localparam int CW = (POW_STEPS > 1) ? $clog2(POW_STEPS) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

  state_t   state;
  opcode_t  opc;
  operand_t op_a;
  operand_t op_b;
  rezultat  pow_acc;
  rezultat  pow_base;
  operand_t pow_exp;
  logic [CW-1:0] pow_cnt;

  rezultat a64;
  rezultat b64;
  rezultat alu_rez;
  logic    alu_bad;
  rezultat pow_acc_next;
  rezultat exec_rez;
  logic    exec_last;

  assign start_ready = (state == IDLE);

  assign a64 = {{32{op_a[31]}}, op_a};
  assign b64 = {{32{op_b[31]}}, op_b};

  // Operands are widened before the arithmetic so ADD/SUB/MULT and the
  // -2^31 / -1 division cannot overflow.
  always_comb begin
    alu_rez = '0;
    alu_bad = 1'b0;
    case (opc)
      ZERO:  alu_rez = '0;
      PASSA: alu_rez = a64;
      PASSB: alu_rez = b64;
      ADD:   alu_rez = a64 + b64;
      SUB:   alu_rez = a64 - b64;
      MULT:  alu_rez = a64 * b64;
      DIV:   if (op_b != 0) alu_rez = a64 / b64;
      MOD:   if (op_b != 0) alu_rez = a64 % b64;
      POW:   alu_rez = '0;
      default: alu_bad = 1'b1;
    endcase
  end

  // Square-and-multiply, exponent consumed LSB first.
  assign pow_acc_next = pow_exp[0] ? (pow_acc * pow_base) : pow_acc;

  always_comb begin
    exec_last = 1'b1;
    exec_rez  = alu_rez;
    if (opc == POW) begin
      exec_last = (pow_cnt == '0);
      exec_rez  = op_b[31] ? '0 : pow_acc_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      read_pointer <= '0;
      opc          <= ZERO;
      op_a         <= '0;
      op_b         <= '0;
      pow_acc      <= '0;
      pow_base     <= '0;
      pow_exp      <= '0;
      pow_cnt      <= '0;
      result_valid <= 1'b0;
      result       <= '0;
      result_opc   <= ZERO;
      result_addr  <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_rez       <= '0;
      bad_opc      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start_valid) begin
            read_pointer <= start_addr;
            bad_opc      <= 1'b0;
            state        <= FETCH;
          end
        end
        FETCH: begin
          opc      <= instruction_word.opc;
          op_a     <= instruction_word.op_a;
          op_b     <= instruction_word.op_b;
          pow_acc  <= 64'sd1;
          pow_base <= {{32{instruction_word.op_a[31]}}, instruction_word.op_a};
          pow_exp  <= instruction_word.op_b;
          pow_cnt  <= CW'(POW_STEPS - 1);
          state    <= EXEC;
        end
        EXEC: begin
          if (opc == POW) begin
            pow_acc  <= pow_acc_next;
            pow_base <= pow_base * pow_base;
            pow_exp  <= pow_exp >> 1;
            if (!exec_last) pow_cnt <= pow_cnt - 1'b1;
          end
          if (exec_last) begin
            result       <= exec_rez;
            wr_rez       <= exec_rez;
            result_opc   <= opc;
            result_addr  <= read_pointer;
            wr_addr      <= read_pointer;
            result_valid <= 1'b1;
            wr_en        <= 1'b1;
            bad_opc      <= alu_bad;
            state        <= DONE;
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_exec_unit.md
INSTR_EXEC_UNIT -- requirements
Module: instr_exec_unit

Interface
REQ-001 SHALL use instr_register_pkg types: opcode_t, operand_t, address_t, rezultat, instruction_t.
REQ-002 SHALL have parameter POW_STEPS, default 32, meaning number of square-and-multiply iterations for POW (one per op_b bit, LSB first).
REQ-003 SHALL have one clock and an asynchronous, active-low reset, on ports clk and reset_n.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 start_valid  input  1  request to execute the instruction at start_addr.
REQ-007 start_addr  input  address_t  instruction register slot to execute.
REQ-008 start_ready  output  1  unit can accept a request.
REQ-009 read_pointer  output  address_t  read address to instruction register.
REQ-010 instruction_word  input  instruction_t  instruction register read data, combinational from read_pointer.
REQ-011 result_valid  output  1  result, result_opc and result_addr are valid.
REQ-012 result_ready  input  1  consumer accepts result.
REQ-013 result  output  rezultat  computed result.
REQ-014 result_opc  output  opcode_t  opcode executed.
REQ-015 result_addr  output  address_t  slot executed.
REQ-016 wr_en  output  1  one-cycle write-back strobe of result into slot wr_addr.
REQ-017 wr_addr  output  address_t  write-back slot.
REQ-018 wr_rez  output  rezultat  write-back value, equal to result.
REQ-019 bad_opc  output  1  sticky until next accept: executed opcode was invalid (encoding 9..15).

Function
REQ-020 FSM states SHALL be IDLE, FETCH, EXEC, DONE; start_ready = 1 only in IDLE.
REQ-021 IDLE: on start_valid && start_ready at edge N, register read_pointer <= start_addr, clear bad_opc, go FETCH; start_valid without ready is ignored.
REQ-022 FETCH: at edge N+1, capture instruction_word into internal opc/op_a/op_b, go EXEC.
REQ-023 EXEC single-cycle ops: at edge N+2, load result, assert result_valid, pulse wr_en for exactly one cycle, go DONE.
REQ-024 ZERO -> 0; PASSA -> sign-extended op_a; PASSB -> sign-extended op_b.
REQ-025 ADD/SUB -> op_a +/- op_b, computed at 64 bits signed, no overflow possible.
REQ-026 MULT -> full 64-bit signed product.
REQ-027 DIV -> op_a / op_b truncated toward zero; MOD -> remainder with sign of op_a; op_b == 0 -> result 0 for both, bad_opc unchanged.
REQ-028 DIV of -2^31 by -1 SHALL yield +2^31 (64-bit result, no wrap).
REQ-029 POW -> op_a^op_b modulo 2^64 (two's complement); op_b < 0 -> 0; op_b == 0 -> 1 (including op_a == 0); computed in EXEC over exactly POW_STEPS cycles, DONE entered at edge N+1+POW_STEPS.
REQ-030 Invalid opcode -> result 0, bad_opc = 1, single-cycle latency.
REQ-031 wr_en SHALL assert on the edge entering DONE only; wr_addr = read_pointer, wr_rez = result.
REQ-032 DONE: result outputs held stable while result_valid && !result_ready; on result_ready go IDLE, result_valid deasserts next cycle.
REQ-033 Next request accepted no earlier than the cycle after DONE exits (no overlap; throughput one instruction per 4 cycles minimum).
REQ-034 result_ready outside DONE SHALL be ignored.

Reset
REQ-035 reset_n low SHALL immediately force IDLE and clear read_pointer, result, result_opc (ZERO), result_addr, wr_addr, wr_rez, internal operands and POW counter to 0.
REQ-036 During and after reset: result_valid = 0, wr_en = 0, bad_opc = 0, start_ready = 1 after reset_n rises.
REQ-037 Reset mid-FETCH/EXEC/DONE SHALL abort with no wr_en pulse and no result_valid after release.

Verification
REQ-038 Slot 3 = {ADD, 7, -10}; start_addr = 3 -> read_pointer = 3 at N+1, result_valid and wr_en at N+3, result = -3, wr_addr = 3.
REQ-039 Slot 5 = {POW, -3, 5}, POW_STEPS = 32 -> result = -243 exactly 32 cycles after FETCH; POW {2, 63} -> 64'h8000_0000_0000_0000; POW {5, -1} -> 0; POW {0, 0} -> 1.
REQ-040 DIV {-7, 2} -> -3, MOD {-7, 2} -> -1, DIV {9, 0} -> 0 with bad_opc = 0; DIV {-2147483648, -1} -> 2147483648.
REQ-041 MULT {-2147483648, -2147483648} -> 4611686018427387904; opcode 4'hC -> result 0, bad_opc = 1.
REQ-042 Hold result_ready = 0 for 10 cycles in DONE -> outputs stable, wr_en pulsed once, start_valid ignored; then result_ready = 1 -> IDLE next cycle.
REQ-043 Assert reset_n = 0 on 10th POW EXEC cycle -> outputs zero immediately, no wr_en; a new ADD request after release completes normally.
